// File: rtl/stack_cpu.sv
// Byte-opcode stack machine: fetches from a synchronous code ROM, runs a data and a call stack,
// latches stack/opcode faults and issues data writes over a valid/ready port.
module stack_cpu #(
   parameter int unsigned DATA_W  = 16,
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned WADDR_W = 16,
   parameter int unsigned DDEPTH  = 8,
   parameter int unsigned CDEPTH  = 8
) (
   input  logic               clock,
   input  logic               reset,
   output logic [ADDR_W-1:0]  code_addr,
   input  logic [7:0]         code_data,
   output logic               wr_valid,
   input  logic               wr_ready,
   output logic [WADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0]  wr_data,
   output logic               halted,
   output logic               fault,
   output logic [2:0]         fault_code
);
   localparam int unsigned DPW = $clog2(DDEPTH);
   localparam int unsigned CPW = $clog2(CDEPTH);
   localparam int unsigned DCW = DPW + 1;
   localparam int unsigned CCW = CPW + 1;

   typedef enum logic [2:0] {StFetch, StExec, StWrite, StHalt, StFault} state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d, pc_inc;
   logic [DCW-1:0]       dcount_q, dcount_d;
   logic [CCW-1:0]       ccount_q, ccount_d;
   logic                 wr_valid_q, wr_valid_d;
   logic [WADDR_W-1:0]   wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0]    wr_data_q, wr_data_d;
   logic                 halted_q, halted_d;
   logic                 fault_q, fault_d;
   logic [2:0]           fault_code_q, fault_code_d;

   logic [DATA_W-1:0]    dstack [DDEPTH];
   logic [ADDR_W-1:0]    cstack [CDEPTH];

   logic [DPW-1:0]       d_free, d_i0, d_i1;
   logic [CPW-1:0]       c_free, c_top;
   logic [DATA_W-1:0]    s0, s1, alu;
   logic [1:0]           need;
   logic                 grows, illegal;
   logic [2:0]           exec_fc;
   logic                 dwe0, dwe1, cwe;
   logic [DPW-1:0]       dwa0, dwa1;
   logic [DATA_W-1:0]    dwd0, dwd1;

   // Pointers are the low bits of the counts; the counts alone decide faults.
   assign d_free = dcount_q[DPW-1:0];
   assign d_i0   = d_free - DPW'(1);
   assign d_i1   = d_free - DPW'(2);
   assign c_free = ccount_q[CPW-1:0];
   assign c_top  = c_free - CPW'(1);
   assign s0     = dstack[d_i0];
   assign s1     = dstack[d_i1];
   assign pc_inc = pc_q + ADDR_W'(1);

   always_comb begin
      need    = 2'd0;
      grows   = 1'b0;
      illegal = 1'b0;
      if (code_data[7]) begin
         grows = 1'b1;
      end else begin
         case (code_data)
            8'h00, 8'h33, 8'h44: need = 2'd0;
            8'h01: begin need = 2'd1; grows = 1'b1; end
            8'h02, 8'h30, 8'h32: need = 2'd1;
            8'h03, 8'h12, 8'h31, 8'h41: need = 2'd2;
            8'h04: begin need = 2'd2; grows = 1'b1; end
            8'h20, 8'h21, 8'h22, 8'h23, 8'h24: need = 2'd2;
            default: illegal = 1'b1;
         endcase
      end
   end

   always_comb begin
      exec_fc = 3'd0;
      if (illegal)                                          exec_fc = 3'd5;
      else if (dcount_q < DCW'(need))                       exec_fc = 3'd2;
      else if (grows && dcount_q == DCW'(DDEPTH))           exec_fc = 3'd1;
      else if (code_data == 8'h32 && ccount_q == CCW'(CDEPTH)) exec_fc = 3'd3;
      else if (code_data == 8'h33 && ccount_q == '0)        exec_fc = 3'd4;
   end

   always_comb begin
      case (code_data[2:0])
         3'd0:    alu = s1 + s0;
         3'd1:    alu = s1 - s0;
         3'd2:    alu = s1 & s0;
         3'd3:    alu = s1 | s0;
         default: alu = s1 ^ s0;
      endcase
   end

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      dcount_d     = dcount_q;
      ccount_d     = ccount_q;
      wr_valid_d   = wr_valid_q;
      wr_addr_d    = wr_addr_q;
      wr_data_d    = wr_data_q;
      halted_d     = halted_q;
      fault_d      = fault_q;
      fault_code_d = fault_code_q;
      dwe0 = 1'b0; dwa0 = '0; dwd0 = '0;
      dwe1 = 1'b0; dwa1 = '0; dwd1 = '0;
      cwe  = 1'b0;
      case (state_q)
         StFetch: state_d = StExec;
         StExec: begin
            if (exec_fc != 3'd0) begin
               fault_d      = 1'b1;
               fault_code_d = exec_fc;
               state_d      = StFault;
            end else begin
               state_d = StFetch;
               pc_d    = pc_inc;
               if (code_data[7]) begin
                  dwe0     = 1'b1;
                  dwa0     = d_free;
                  dwd0     = {{(DATA_W-7){code_data[6]}}, code_data[6:0]};
                  dcount_d = dcount_q + DCW'(1);
               end else begin
                  case (code_data)
                     8'h01: begin
                        dwe0 = 1'b1; dwa0 = d_free; dwd0 = s0;
                        dcount_d = dcount_q + DCW'(1);
                     end
                     8'h02: dcount_d = dcount_q - DCW'(1);
                     8'h03: begin
                        dwe0 = 1'b1; dwa0 = d_i0; dwd0 = s1;
                        dwe1 = 1'b1; dwa1 = d_i1; dwd1 = s0;
                     end
                     8'h04: begin
                        dwe0 = 1'b1; dwa0 = d_free; dwd0 = s1;
                        dcount_d = dcount_q + DCW'(1);
                     end
                     8'h20, 8'h21, 8'h22, 8'h23, 8'h24: begin
                        dwe0 = 1'b1; dwa0 = d_i1; dwd0 = alu;
                        dcount_d = dcount_q - DCW'(1);
                     end
                     8'h12: begin
                        wr_addr_d  = s0[WADDR_W-1:0];
                        wr_data_d  = s1;
                        wr_valid_d = 1'b1;
                        dcount_d   = dcount_q - DCW'(2);
                        state_d    = StWrite;
                     end
                     8'h30: begin
                        pc_d     = s0[ADDR_W-1:0];
                        dcount_d = dcount_q - DCW'(1);
                     end
                     8'h31: begin
                        if (s1 == '0) pc_d = s0[ADDR_W-1:0];
                        dcount_d = dcount_q - DCW'(2);
                     end
                     8'h32: begin
                        cwe      = 1'b1;
                        pc_d     = s0[ADDR_W-1:0];
                        ccount_d = ccount_q + CCW'(1);
                        dcount_d = dcount_q - DCW'(1);
                     end
                     8'h33: begin
                        pc_d     = cstack[c_top];
                        ccount_d = ccount_q - CCW'(1);
                     end
                     8'h41: dcount_d = dcount_q - DCW'(2);
                     8'h44: begin
                        halted_d = 1'b1;
                        state_d  = StHalt;
                     end
                     default: ;
                  endcase
               end
            end
         end
         StWrite: begin
            if (wr_ready) begin
               wr_valid_d = 1'b0;
               state_d    = StFetch;
            end
         end
         StHalt, StFault: ;
         default: state_d = StFetch;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= StFetch;
         pc_q         <= '0;
         dcount_q     <= '0;
         ccount_q     <= '0;
         wr_valid_q   <= 1'b0;
         wr_addr_q    <= '0;
         wr_data_q    <= '0;
         halted_q     <= 1'b0;
         fault_q      <= 1'b0;
         fault_code_q <= 3'd0;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         dcount_q     <= dcount_d;
         ccount_q     <= ccount_d;
         wr_valid_q   <= wr_valid_d;
         wr_addr_q    <= wr_addr_d;
         wr_data_q    <= wr_data_d;
         halted_q     <= halted_d;
         fault_q      <= fault_d;
         fault_code_q <= fault_code_d;
      end
   end

   // Stack storage is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (dwe0) dstack[dwa0] <= dwd0;
      if (dwe1) dstack[dwa1] <= dwd1;
      if (cwe)  cstack[c_free] <= pc_inc;
   end

`ifdef TESTBENCH
   always_ff @(posedge clock) begin
      if (state_q == StExec && exec_fc == 3'd0 && code_data == 8'h41)
         $display("stack_cpu print: %0h %0h", s1, s0);
   end
`endif

   assign code_addr  = pc_q;
   assign wr_valid   = wr_valid_q;
   assign wr_addr    = wr_addr_q;
   assign wr_data    = wr_data_q;
   assign halted     = halted_q;
   assign fault      = fault_q;
   assign fault_code = fault_code_q;
endmodule

// File: tb/tb_stack_cpu.sv
// Bench for stack_cpu: table of small programs plus hand-written sequences for write
// back-pressure, call/ret and reset during a write; writes are checked against a scoreboard.
module tb_stack_cpu;
   localparam int unsigned DATA_W  = 16;
   localparam int unsigned ADDR_W  = 12;
   localparam int unsigned WADDR_W = 16;
   localparam int unsigned DDEPTH  = 4;
   localparam int unsigned CDEPTH  = 2;

   logic               clock = 1'b0;
   logic               reset = 1'b1;
   logic [ADDR_W-1:0]  code_addr;
   logic [7:0]         code_data;
   logic               wr_valid;
   logic               wr_ready = 1'b1;
   logic [WADDR_W-1:0] wr_addr;
   logic [DATA_W-1:0]  wr_data;
   logic               halted, fault;
   logic [2:0]         fault_code;

   stack_cpu #(
      .DATA_W(DATA_W), .ADDR_W(ADDR_W), .WADDR_W(WADDR_W), .DDEPTH(DDEPTH), .CDEPTH(CDEPTH)
   ) dut (
      .clock(clock), .reset(reset), .code_addr(code_addr), .code_data(code_data),
      .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
      .halted(halted), .fault(fault), .fault_code(fault_code)
   );

   always #5 clock = ~clock;

   logic [7:0] rom [4096];
   always @(posedge clock) code_data <= rom[code_addr];

   typedef struct {
      logic [95:0]        prog;
      logic               exp_halt;
      logic [2:0]         exp_fc;
      logic [ADDR_W-1:0]  exp_pc;
      int                 exp_dcount;
      logic               has_wr;
      logic [WADDR_W-1:0] waddr;
      logic [DATA_W-1:0]  wdata;
   } vec_t;
   typedef struct {
      logic [WADDR_W-1:0] a;
      logic [DATA_W-1:0]  d;
   } wr_t;

   vec_t vecs[$];
   wr_t  exp_q[$];
   int checks = 0;
   int errors = 0;
   int n_writes, n_stalls, stall_left;
   logic holding, saw_valid, seen_target;
   logic [WADDR_W-1:0] held_addr;
   logic [DATA_W-1:0]  held_data;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic add_vec(input logic [95:0] p, input logic h, input int fc, input int pc,
                          input int dc, input logic w, input int wa, input int wd);
      vec_t v;
      v.prog = p; v.exp_halt = h; v.exp_fc = 3'(fc); v.exp_pc = ADDR_W'(pc);
      v.exp_dcount = dc; v.has_wr = w; v.waddr = WADDR_W'(wa); v.wdata = DATA_W'(wd);
      vecs.push_back(v);
   endtask

   task automatic load_prog(input logic [95:0] p);
      for (int i = 0; i < 4096; i++) rom[i] = 8'h00;
      for (int i = 0; i < 12; i++) rom[i] = p[95-8*i -: 8];
   endtask

   // One clock: observe the write port at the falling edge, then drive wr_ready after the rise.
   task automatic tick();
      wr_t e;
      @(negedge clock);
      if (code_addr == ADDR_W'(16)) seen_target = 1'b1;
      if (wr_valid) begin
         saw_valid = 1'b1;
         if (holding) begin
            check("wr_addr_stable", 32'(wr_addr), 32'(held_addr));
            check("wr_data_stable", 32'(wr_data), 32'(held_data));
         end
         if (wr_ready) begin
            n_writes++;
            holding = 1'b0;
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                        wr_addr, wr_data);
            end else begin
               e = exp_q.pop_front();
               check("write_addr", 32'(wr_addr), 32'(e.a));
               check("write_data", 32'(wr_data), 32'(e.d));
            end
         end else begin
            n_stalls++;
            if (stall_left > 0) stall_left--;
            holding   = 1'b1;
            held_addr = wr_addr;
            held_data = wr_data;
         end
      end else begin
         holding = 1'b0;
      end
      @(posedge clock);
      #1;
      wr_ready = (stall_left == 0);
   endtask

   task automatic do_reset();
      reset   = 1'b1;
      holding = 1'b0;
      repeat (2) tick();
      reset = 1'b0;
   endtask

   task automatic start(input int stall);
      stall_left = stall;
      wr_ready   = (stall == 0);
      n_writes = 0; n_stalls = 0;
      saw_valid = 1'b0; seen_target = 1'b0;
      exp_q.delete();
   endtask

   task automatic run(input string name);
      int i;
      for (i = 0; i < 400; i++) begin
         if (halted || fault) break;
         tick();
      end
      if (!(halted || fault)) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got no halt/fault after %0d cycles, required halt or fault",
                  name, i);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got simulation still running, required completion");
      $fatal(1);
   end

   initial begin
      wr_t w;
      //       program bytes                     halt fc  pc  dc  wr  addr    data
      add_vec(96'h8283_2090_1244_0000_0000_0000, 1, 0,  6, 0, 1, 'h0010, 'h0005);
      add_vec(96'h85FF_2181_1244_0000_0000_0000, 1, 0,  6, 0, 1, 'h0001, 'h0006);
      add_vec(96'h8F83_2284_2381_2480_1244_0000, 1, 0, 10, 0, 1, 'h0000, 'h0006);
      add_vec(96'h8182_0304_0212_4400_0000_0000, 1, 0,  7, 0, 1, 'h0001, 'h0002);
      add_vec(96'h8081_2180_1244_0000_0000_0000, 1, 0,  6, 0, 1, 'h0000, 'hFFFF);
      add_vec(96'hC081_1244_0000_0000_0000_0000, 1, 0,  4, 0, 1, 'h0001, 'hFFC0);
      add_vec(96'h8084_3155_4400_0000_0000_0000, 1, 0,  5, 0, 0, 0, 0);
      add_vec(96'h8184_3144_5500_0000_0000_0000, 1, 0,  4, 0, 0, 0, 0);
      add_vec(96'h8330_5544_0000_0000_0000_0000, 1, 0,  4, 0, 0, 0, 0);
      add_vec(96'h8182_4144_0000_0000_0000_0000, 1, 0,  4, 0, 0, 0, 0);
      add_vec(96'h0000_4400_0000_0000_0000_0000, 1, 0,  3, 0, 0, 0, 0);
      add_vec(96'h8181_8181_8100_0000_0000_0000, 0, 1,  4, 4, 0, 0, 0);
      add_vec(96'h8181_8181_0100_0000_0000_0000, 0, 1,  4, 4, 0, 0, 0);
      add_vec(96'h2000_0000_0000_0000_0000_0000, 0, 2,  0, 0, 0, 0, 0);
      add_vec(96'h8112_0000_0000_0000_0000_0000, 0, 2,  1, 1, 0, 0, 0);
      add_vec(96'h5500_0000_0000_0000_0000_0000, 0, 5,  0, 0, 0, 0, 0);
      add_vec(96'h0500_0000_0000_0000_0000_0000, 0, 5,  0, 0, 0, 0, 0);
      add_vec(96'h3300_0000_0000_0000_0000_0000, 0, 4,  0, 0, 0, 0, 0);

      // Reset state, sampled while reset is held.
      start(0);
      load_prog(96'h0);
      holding = 1'b0;
      tick();
      check("rst_code_addr", 32'(code_addr), 32'h0);
      check("rst_wr_valid", 32'(wr_valid), 32'h0);
      check("rst_wr_addr", 32'(wr_addr), 32'h0);
      check("rst_wr_data", 32'(wr_data), 32'h0);
      check("rst_halted", 32'(halted), 32'h0);
      check("rst_fault", 32'(fault), 32'h0);
      check("rst_fault_code", 32'(fault_code), 32'h0);

      foreach (vecs[k]) begin
         start(0);
         load_prog(vecs[k].prog);
         if (vecs[k].has_wr) begin
            w.a = vecs[k].waddr; w.d = vecs[k].wdata;
            exp_q.push_back(w);
         end
         do_reset();
         run($sformatf("vec%0d", k));
         check($sformatf("vec%0d_halted", k), 32'(halted), 32'(vecs[k].exp_halt));
         check($sformatf("vec%0d_fault", k), 32'(fault), 32'(vecs[k].exp_fc != 3'd0));
         check($sformatf("vec%0d_fault_code", k), 32'(fault_code), 32'(vecs[k].exp_fc));
         check($sformatf("vec%0d_pc", k), 32'(code_addr), 32'(vecs[k].exp_pc));
         check($sformatf("vec%0d_dcount", k), 32'(dut.dcount_q), 32'(vecs[k].exp_dcount));
         check($sformatf("vec%0d_nwrites", k), 32'(n_writes), 32'(vecs[k].has_wr));
         check($sformatf("vec%0d_saw_valid", k), 32'(saw_valid), 32'(vecs[k].has_wr));
         check($sformatf("vec%0d_sb_empty", k), 32'(exp_q.size()), 32'h0);
      end

      // Back-pressure: ready held low for 5 valid cycles.
      start(5);
      load_prog(96'h8283_2090_1244_0000_0000_0000);
      w.a = 16'h0010; w.d = 16'h0005;
      exp_q.push_back(w);
      do_reset();
      run("stall");
      check("stall_cycles", 32'(n_stalls), 32'd5);
      check("stall_nwrites", 32'(n_writes), 32'd1);
      check("stall_halted", 32'(halted), 32'h1);
      check("stall_sb_empty", 32'(exp_q.size()), 32'h0);

      // call 0x10, ret, halt at 2.
      start(0);
      load_prog(96'h9032_4400_0000_0000_0000_0000);
      rom[16] = 8'h33;
      do_reset();
      run("callret");
      check("callret_halted", 32'(halted), 32'h1);
      check("callret_fault", 32'(fault), 32'h0);
      check("callret_pc", 32'(code_addr), 32'h3);
      check("callret_visited", 32'(seen_target), 32'h1);
      check("callret_ccount", 32'(dut.ccount_q), 32'h0);

      // Self-recursive call overflows a 2-entry call stack on the 3rd call.
      start(0);
      load_prog(96'h8032_0000_0000_0000_0000_0000);
      do_reset();
      run("recurse");
      check("recurse_fault_code", 32'(fault_code), 32'h3);
      check("recurse_pc", 32'(code_addr), 32'h1);
      check("recurse_ccount", 32'(dut.ccount_q), 32'h2);
      check("recurse_dcount", 32'(dut.dcount_q), 32'h1);

      // Reset while a write is pending must drop wr_valid at once.
      start(1000);
      load_prog(96'h8283_2090_1244_0000_0000_0000);
      w.a = 16'h0010; w.d = 16'h0005;
      exp_q.push_back(w);
      do_reset();
      for (int i = 0; i < 100; i++) begin
         if (wr_valid) break;
         tick();
      end
      check("midwr_valid_before", 32'(wr_valid), 32'h1);
      reset = 1'b1;
      #1;
      check("midwr_valid_async", 32'(wr_valid), 32'h0);
      check("midwr_code_addr", 32'(code_addr), 32'h0);
      exp_q.delete();
      stall_left = 0;
      wr_ready   = 1'b1;
      holding    = 1'b0;
      tick();
      reset = 1'b0;
      check("restart_fault", 32'(fault), 32'h0);
      check("restart_halted", 32'(halted), 32'h0);
      check("restart_code_addr", 32'(code_addr), 32'h0);
      n_writes = 0;
      exp_q.push_back(w);
      run("restart");
      check("restart_done_halted", 32'(halted), 32'h1);
      check("restart_nwrites", 32'(n_writes), 32'h1);
      check("restart_pc", 32'(code_addr), 32'h6);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/stack_cpu.md
Name: stack_cpu

Overview:
Parametrised successor to the team's 8-bit-opcode stack machine. Fetches opcodes from an external synchronous code ROM and executes them on a data stack and a call stack, both of configurable depth. Data writes go out through a valid/ready handshake. Stack overflow, stack underflow and illegal opcodes are detected and latched. Sits between the code ROM and the sprite/video register write bus.

Parameters:
DATA_W, 16, data stack word width and write-data width (≥8)
ADDR_W, 12, code address width and call-stack entry width
WADDR_W, 16, write-address width (≤ DATA_W; taken from S0 LSBs)
DDEPTH, 8, data stack entries (power of 2, ≥4)
CDEPTH, 8, call stack entries (power of 2, ≥2)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high
code_addr  out  ADDR_W  ROM read address, registered
code_data  in  8  ROM data, valid one cycle after code_addr
wr_valid  out  1  write request
wr_ready  in  1  write accepted when wr_valid & wr_ready at posedge
wr_addr  out  WADDR_W  write address, stable while wr_valid
wr_data  out  DATA_W  write data, stable while wr_valid
halted  out  1  HALT executed, sticky
fault  out  1  fault latched, sticky
fault_code  out  3  0 none, 1 dstack overflow, 2 dstack underflow, 3 cstack overflow, 4 cstack underflow, 5 illegal opcode

Behaviour:
- Reset (async): pc=0, code_addr=0, dcount=0, ccount=0, state=FETCH, wr_valid=0, wr_addr=0, wr_data=0, halted=0, fault=0, fault_code=0. Stack RAM contents are not cleared.
- S0 = top of stack, S1 = next. dcount ranges 0..DDEPTH; ccount ranges 0..CDEPTH.
- FSM states: FETCH, EXEC, WRITE, HALT, FAULT.
- FETCH: code_addr=pc. Next state EXEC.
- EXEC: decode code_data; pc<=pc+1 unless the opcode redirects it; next state FETCH unless stated otherwise. Each instruction takes 2 cycles; a store takes ≥3.
- Opcode map:
  - 1iiiiiii: push sign-extended 7-bit immediate to DATA_W.
  - 0x00 nop.
  - 0x01 dup (needs 1, pushes 1).
  - 0x02 drop (needs 1).
  - 0x03 swap (needs 2).
  - 0x04 over (needs 2, pushes 1).
  - 0x20..0x24: S1 op S0 with op = add, sub, and, or, xor; result replaces S1, pop 1. add/sub wrap modulo 2^DATA_W.
  - 0x12 store: wr_addr<=S0[WADDR_W-1:0], wr_data<=S1, pop 2, wr_valid<=1, go to WRITE.
  - 0x30 jmp: pc<=S0[ADDR_W-1:0], pop 1.
  - 0x31 jz: if S1==0 then pc<=S0 else pc+1; pop 2.
  - 0x32 call: cstack push pc+1, pc<=S0, pop 1.
  - 0x33 ret: pc<=cstack top, cpop.
  - 0x41 print: $display S1,S0 under TESTBENCH only; pop 2.
  - 0x44 halt: go to HALT, halted<=1.
  - Every other value: illegal.
- WRITE: hold wr_valid, wr_addr and wr_data until a cycle with wr_ready=1; in that cycle wr_valid<=0 and next state is FETCH. If wr_ready is already high in the first WRITE cycle, the write completes in one cycle.
- Fault checks happen in EXEC before any state change.
  - Underflow: dcount < required operands.
  - Overflow: net push with dcount==DDEPTH.
  - Call stack: call with ccount==CDEPTH; ret with ccount==0.
  - Illegal opcode.
  - On fault: no stack, pc or write update; fault<=1; fault_code set; go to FAULT.
  - If several conditions apply, the code priority is illegal > underflow > overflow.
- HALT and FAULT are terminal until reset. code_addr is frozen and wr_valid=0.
- pc and code_addr wrap modulo 2^ADDR_W. Stack pointers wrap internally; dcount governs all checks.
- Reset asserted in WRITE drops wr_valid immediately (async) and abandons the write.

Test Plan:
- ROM 0x82,0x83,0x20,0x90,0x12,0x44 (DATA_W=16) -> one write with wr_addr=0x0010, wr_data=0x0005; halted=1; dcount=0.
- Same program with wr_ready held low 5 cycles -> wr_valid high and wr_addr/wr_data stable for all 5 cycles; single accepted write; no extra write.
- ROM 0x85,0xFF,0x21,0x81,0x12 then halt -> wr_addr=1, wr_data=0x0006 (5 - (-1)).
- Call/ret: push target 0x10 (0x90), 0x32; at 0x10: 0x33; caller continues at address 2 with 0x44 -> halted at pc=3; with CDEPTH=2, recursive call to self -> fault_code=3 after the 3rd call.
- DDEPTH=4: five 0x81 pushes -> fault_code=1 on the 5th with dcount=4; separately 0x20 on an empty stack -> fault_code=2; opcode 0x55 -> fault_code=5; wr_valid never asserted.
- Assert reset mid-WRITE -> wr_valid=0 the same cycle; after release, execution restarts at code_addr=0 with fault=0 and halted=0.
